st7735_spi_tx: RTL and testbench
================================

Name: st7735_spi_tx

Overview:
Byte-level SPI transmitter directly downstream of the ST7735 command/pixel sequencer. It drives the panel's spi_cs, spi_dc, spi_clk and spi_mosi pins.
- Accepts {dc, byte} entries over a valid/ready handshake into a small FIFO.
- Serialises each byte MSB-first in SPI mode 0 (clock idles low, panel samples on rising edge).
- Holds CS low across back-to-back bytes.
- Behaviour is bit-exact regardless of how the sequencer paces its writes.

Parameters:
- CLK_DIV, 2: clk cycles per spi_clk half-period; legal range ≥1.
- FIFO_DEPTH, 4: number of {dc, byte} entries buffered; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sequencer presents an entry.
- in_ready  out  1  FIFO not full; transfer occurs when in_valid && in_ready at a clk rising edge.
- in_data  in  8  byte to send.
- in_dc  in  1  0 = command, 1 = data; travels with the byte.
- spi_cs  out  1  panel chip select, active low.
- spi_dc  out  1  panel data/command line.
- spi_clk  out  1  SPI clock, idles low.
- spi_mosi  out  1  serial data, MSB first.
- busy  out  1  FIFO non-empty or engine not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - spi_cs=1, spi_clk=0, spi_mosi=0, spi_dc=0, busy=0, in_ready=1.
  - FIFO flushed, state=IDLE, bit and divider counters cleared.
  - A reset mid-byte aborts the byte immediately; the partial byte and queued entries are discarded.
- All outputs are registered except in_ready (=!full) and busy (=!empty || state!=IDLE).
- FIFO:
  - Push on in_valid && in_ready.
  - Pop only by the engine.
  - When full, in_ready=0 even if a pop happens in the same cycle (no pass-through).
  - Push and pop in the same cycle when not full are both honoured.
  - Strict order is preserved.
- States:
  - IDLE: spi_cs=1, spi_clk=0. If FIFO non-empty: pop; load shift register; spi_dc<=entry.dc; spi_mosi<=bit7; spi_cs<=0; bitcnt<=7; divcnt<=0; go LOW.
  - LOW: spi_clk=0 for CLK_DIV cycles, then spi_clk<=1; go HIGH.
  - HIGH: spi_clk=1 for CLK_DIV cycles, then spi_clk<=0.
    - If bitcnt>0: shift, spi_mosi<=next bit, bitcnt--, go LOW.
    - Else if FIFO non-empty: pop, reload exactly as in IDLE but spi_cs stays 0; go LOW.
    - Else go HOLD.
  - HOLD: spi_cs=0, spi_clk=0 for CLK_DIV cycles; then spi_cs<=1; go IDLE.
- Timing and latency:
  - One byte = 16*CLK_DIV clk cycles from load to the final falling edge.
  - A burst ends with CLK_DIV hold cycles.
  - Back-to-back bytes have no gap: the next rising edge follows the previous one by exactly 2*CLK_DIV cycles.
  - spi_mosi and spi_dc change only while spi_clk is low, or at the falling edge; they are stable for CLK_DIV cycles before every rising edge.
  - Handshake at edge N: the entry is in the FIFO after edge N; IDLE pops it at edge N+1, so spi_cs falls at edge N+1. First spi_clk rise is at edge N+1+CLK_DIV.

Decomposition:
- Package st7735_pkg holds:
  - ST7735_DC_CMD=0, ST7735_DC_DATA=1.
  - The 9-bit entry typedef {dc, data[7:0]}.
  - The state enum IDLE/LOW/HIGH/HOLD.
  - Default CLK_DIV and FIFO_DEPTH.
- Sub-module st7735_byte_fifo:
  - Synchronous FIFO, width 9, depth FIFO_DEPTH.
  - Pointer-based, with an extra wrap bit for full/empty.
  - Async active-low reset.

Test Plan:
- Reset: rst_n=0 for 3 cycles → spi_cs=1, spi_clk=0, spi_mosi=0, spi_dc=0, busy=0, in_ready=1; no spi_clk edges for 20 cycles after release with in_valid=0.
- Single command byte (CLK_DIV=2): push 0xA5 dc=0 → spi_cs falls 1 edge after handshake; exactly 8 rising spi_clk edges sampling 1,0,1,0,0,1,0,1; spi_dc=0 on each; spi_cs returns high 34 cycles after it fell (32 + 2 hold).
- Burst with dc switch: push 0x2A dc=0, 0x00 dc=1, 0x7F dc=1 consecutively →
  - spi_cs stays low throughout; 24 rising edges, each 4 cycles apart.
  - Edge 9 is the first with spi_dc=1; spi_dc changes only while spi_clk=0.
  - Bytes received are 0x2A, 0x00, 0x7F.
- Backpressure: hold in_valid=1 with 8 distinct bytes → in_ready deasserts once the FIFO holds 4 entries; no byte is lost or duplicated; received order equals push order; busy stays 1 until the final spi_cs rise.
- Reset mid-byte: with 3 bytes queued, pull rst_n low right after the 3rd rising edge of byte 1 → all outputs take reset values immediately; after release there is no further spi_clk activity and busy=0.
- CLK_DIV=1: push 0x3C → spi_clk period is 2 clk cycles; byte spans 16 cycles; received value is 0x3C; spi_cs rises 1 cycle after the final falling edge.

Source files
------------

// File: rtl/st7735_pkg.sv
// st7735_pkg: shared types and defaults for the ST7735 SPI byte transmitter.
//   ST7735_DC_CMD / ST7735_DC_DATA : values of the panel D/C line
//   st7735_entry_t                 : one queued {dc, data[7:0]} entry
//   st7735_state_t                 : serialiser engine states
package st7735_pkg;

  localparam logic ST7735_DC_CMD  = 1'b0;
  localparam logic ST7735_DC_DATA = 1'b1;

  localparam int ST7735_CLK_DIV_DEF    = 2;
  localparam int ST7735_FIFO_DEPTH_DEF = 4;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } st7735_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_HOLD
  } st7735_state_t;

endpackage

// File: rtl/st7735_spi_tx_if.sv
// st7735_spi_tx_if: valid/ready byte stream from the command/pixel sequencer.
//   in_valid : sequencer presents an entry
//   in_ready : transmitter can accept an entry this cycle
//   in_data  : byte to send
//   in_dc    : 0 = command, 1 = data
//   master   : sequencer side, slave : transmitter side
interface st7735_spi_tx_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_dc;

  modport master (output in_valid, output in_data, output in_dc, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_dc, output in_ready);

endinterface

// File: rtl/st7735_byte_fifo.sv
// st7735_byte_fifo: synchronous FIFO of {dc, byte} entries.
//   clk, rst_n : clock, async active-low reset (flushes the pointers)
//   push/wdata : write when push && !full
//   pop/rdata  : rdata is the head entry; advance when pop && !empty
//   full/empty : occupancy flags from pointers carrying an extra wrap bit
module st7735_byte_fifo
  import st7735_pkg::*;
#(
  parameter int DEPTH = ST7735_FIFO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  st7735_entry_t wdata,
  input  logic          pop,
  output st7735_entry_t rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  st7735_entry_t mem [DEPTH];

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/st7735_spi_tx.sv
// st7735_spi_tx: byte-level SPI mode-0 transmitter for the ST7735 panel.
//   clk, rst_n : system clock, async active-low reset
//   in_if      : valid/ready entry stream (slave side); in_ready = FIFO not full
//   spi_cs     : chip select, active low, held low across back-to-back bytes
//   spi_dc     : data/command line, travels with each byte
//   spi_clk    : SPI clock, idles low, CLK_DIV clk cycles per half-period
//   spi_mosi   : serial data, MSB first
//   busy       : FIFO non-empty or engine not idle
//
// state   | meaning
// IDLE    | cs high, waiting for an entry
// LOW     | spi_clk low phase, mosi/dc already set up
// HIGH    | spi_clk high phase, panel has sampled the bit
// HOLD    | cs still low after the last byte of a burst
module st7735_spi_tx
  import st7735_pkg::*;
#(
  parameter int CLK_DIV    = ST7735_CLK_DIV_DEF,
  parameter int FIFO_DEPTH = ST7735_FIFO_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  st7735_spi_tx_if.slave  in_if,
  output logic            spi_cs,
  output logic            spi_dc,
  output logic            spi_clk,
  output logic            spi_mosi,
  output logic            busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  st7735_state_t state;
  st7735_entry_t wr_entry;
  st7735_entry_t head;
  logic          full;
  logic          empty;
  logic          pop;
  logic [6:0]    shreg;
  logic [2:0]    bitcnt;
  logic [DW-1:0] divcnt;
  logic          div_done;

  assign wr_entry = {in_if.in_dc, in_if.in_data};

  st7735_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_if.in_valid),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign in_if.in_ready = !full;
  assign busy           = !empty || (state != ST_IDLE);
  assign div_done       = (divcnt == DIV_LAST);

  // The next byte is loaded on the falling edge that ends bit 0, so a
  // back-to-back byte keeps the 2*CLK_DIV rising-edge rhythm.
  assign pop = !empty && ((state == ST_IDLE) ||
                          (state == ST_HIGH && div_done && bitcnt == 3'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_dc   <= 1'b0;
      shreg    <= '0;
      bitcnt   <= '0;
      divcnt   <= '0;
    end else if (pop) begin
      state    <= ST_LOW;
      spi_cs   <= 1'b0;
      spi_clk  <= 1'b0;
      spi_dc   <= head.dc;
      spi_mosi <= head.data[7];
      shreg    <= head.data[6:0];
      bitcnt   <= 3'd7;
      divcnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          spi_cs  <= 1'b1;
          spi_clk <= 1'b0;
        end
        ST_LOW: begin
          if (div_done) begin
            spi_clk <= 1'b1;
            divcnt  <= '0;
            state   <= ST_HIGH;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (div_done) begin
            spi_clk <= 1'b0;
            divcnt  <= '0;
            if (bitcnt != 3'd0) begin
              spi_mosi <= shreg[6];
              shreg    <= {shreg[5:0], 1'b0};
              bitcnt   <= bitcnt - 3'd1;
              state    <= ST_LOW;
            end else begin
              state <= ST_HOLD;
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (div_done) begin
            spi_cs <= 1'b1;
            divcnt <= '0;
            state  <= ST_IDLE;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_st7735_spi_tx.sv
// tb_st7735_spi_tx: self-checking bench for st7735_spi_tx.
//   dut  : CLK_DIV=2, FIFO_DEPTH=4, compared every cycle against a timeline model
//   dut1 : CLK_DIV=1, checked with hand-computed timing and data
module tb_st7735_spi_tx;
  import st7735_pkg::*;

  localparam int MD    = 2;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  st7735_spi_tx_if ifc ();
  st7735_spi_tx_if ifc1 ();

  logic cs, dc, sclk, mosi, busy;
  logic cs1, dc1, sclk1, mosi1, busy1;

  st7735_spi_tx #(.CLK_DIV(MD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_if(ifc),
    .spi_cs(cs), .spi_dc(dc), .spi_clk(sclk), .spi_mosi(mosi), .busy(busy)
  );

  st7735_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_if(ifc1),
    .spi_cs(cs1), .spi_dc(dc1), .spi_clk(sclk1), .spi_mosi(mosi1), .busy(busy1)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  bit saw_not_ready = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: once an entry is loaded at time t=0, spi_clk is high in
  // the odd CLK_DIV-long slots and bit i is presented for slots 2i and 2i+1.
  logic [8:0] mq[$];
  logic [8:0] cur = '0;
  int  mmode = 0;  // 0 idle, 1 shifting, 2 hold
  int  mt    = 0;
  bit  room;
  logic m_cs = 1'b1, m_clk = 1'b0, m_mosi = 1'b0, m_dc = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mmode = 0; mt = 0; cur = '0;
      m_cs = 1'b1; m_clk = 1'b0; m_mosi = 1'b0; m_dc = 1'b0;
    end else begin
      room = (mq.size() < DEPTH);
      case (mmode)
        0: if (mq.size() > 0) begin cur = mq.pop_front(); mmode = 1; mt = 0; end
        1: begin
          mt++;
          if (mt == 16 * MD) begin
            if (mq.size() > 0) begin cur = mq.pop_front(); mt = 0; end
            else begin mmode = 2; mt = 0; end
          end
        end
        default: begin mt++; if (mt == MD) mmode = 0; end
      endcase
      if (ifc.in_valid && room) mq.push_back({ifc.in_dc, ifc.in_data});
      if (mmode == 1) begin
        m_clk  = ((mt / MD) % 2) == 1;
        m_mosi = cur[7 - mt / (2 * MD)];
        m_dc   = cur[8];
      end else begin
        m_clk = 1'b0;
      end
      m_cs = (mmode == 0);
    end
  end

  always @(negedge clk) begin
    chk("cs", cs, m_cs);
    chk("spi_clk", sclk, m_clk);
    chk("mosi", mosi, m_mosi);
    chk("dc", dc, m_dc);
    chk("busy", busy, (mq.size() > 0) || (mmode != 0));
    chk("in_ready", ifc.in_ready, mq.size() < DEPTH);
  end

  // Receiver / pin monitors
  int   rise_cyc[$];
  logic rise_bit[$], rise_dc[$], rise_cs[$];
  int   cs_fall_cyc = -1, cs_rise_cyc = -1, cs_rise_n = 0, stab_bad = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_dc = 1'b0, p_mosi = 1'b0;

  always @(negedge clk) begin
    if (sclk && !p_sclk) begin
      rise_cyc.push_back(cyc); rise_bit.push_back(mosi);
      rise_dc.push_back(dc);   rise_cs.push_back(cs);
    end
    if (!cs && p_cs) cs_fall_cyc = cyc;
    if (cs && !p_cs) begin cs_rise_cyc = cyc; cs_rise_n++; end
    if (sclk && ((dc !== p_dc) || (mosi !== p_mosi))) stab_bad++;
    p_sclk = sclk; p_cs = cs; p_dc = dc; p_mosi = mosi;
  end

  int   r1_cyc[$];
  logic r1_bit[$];
  int   fall1_cyc = -1, cs1_fall = -1, cs1_rise = -1;
  logic p_sclk1 = 1'b0, p_cs1 = 1'b1;

  always @(negedge clk) begin
    if (sclk1 && !p_sclk1) begin r1_cyc.push_back(cyc); r1_bit.push_back(mosi1); end
    if (!sclk1 && p_sclk1) fall1_cyc = cyc;
    if (!cs1 && p_cs1) cs1_fall = cyc;
    if (cs1 && !p_cs1) cs1_rise = cyc;
    p_sclk1 = sclk1; p_cs1 = cs1;
  end

  task automatic clear_mon();
    rise_cyc.delete(); rise_bit.delete(); rise_dc.delete(); rise_cs.delete();
    cs_fall_cyc = -1; cs_rise_cyc = -1; cs_rise_n = 0; stab_bad = 0;
    r1_cyc.delete(); r1_bit.delete();
    fall1_cyc = -1; cs1_fall = -1; cs1_rise = -1;
  endtask

  function automatic logic [7:0] rxb(input int k);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (k + i < rise_bit.size()) v = {v[6:0], rise_bit[k + i]};
    return v;
  endfunction

  // Called at posedge+1; returns the cycle number of the handshake edge.
  task automatic push(input int which, input logic d, input logic [7:0] b, output int hs);
    logic r;
    r  = 1'b0;
    hs = -1;
    if (which == 0) begin ifc.in_valid = 1'b1; ifc.in_dc = d; ifc.in_data = b; end
    else begin ifc1.in_valid = 1'b1; ifc1.in_dc = d; ifc1.in_data = b; end
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      r = (which == 0) ? ifc.in_ready : ifc1.in_ready;
      if (!r) saw_not_ready = 1;
      @(posedge clk); #1;
      if (r) break;
    end
    if (which == 0) ifc.in_valid = 1'b0; else ifc1.in_valid = 1'b0;
    if (r) hs = cyc;
    chk("push_accepted", r, 1'b1);
  endtask

  task automatic wait_idle(input int which);
    bit done;
    done = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (((which == 0) ? busy : busy1) == 1'b0) begin done = 1; break; end
    end
    chk("idle_timeout", done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_cs"}, cs, 1'b1);
    chk({tag, "_clk"}, sclk, 1'b0);
    chk({tag, "_mosi"}, mosi, 1'b0);
    chk({tag, "_dc"}, dc, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, ifc.in_ready, 1'b1);
  endtask

  int hs, hs0, bad, ones, first_dc;
  logic [7:0] exp_b [8];
  logic [7:0] v;

  initial begin
    ifc.in_valid = 1'b0;  ifc.in_dc = 1'b0;  ifc.in_data = '0;
    ifc1.in_valid = 1'b0; ifc1.in_dc = 1'b0; ifc1.in_data = '0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk_reset_pins("rst");
    rst_n = 1'b1;
    clear_mon();
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_edges", rise_cyc.size(), 0);

    // Single command byte
    clear_mon();
    push(0, ST7735_DC_CMD, 8'hA5, hs);
    wait_idle(0);
    chk("single_cs_fall", cs_fall_cyc, hs + 1);
    chk("single_first_rise", rise_cyc.size() > 0 ? rise_cyc[0] : -1, hs + 1 + MD);
    chk("single_edges", rise_cyc.size(), 8);
    chk("single_byte", rxb(0), 8'hA5);
    ones = 0;
    foreach (rise_dc[i]) if (rise_dc[i]) ones++;
    chk("single_dc", ones, 0);
    chk("single_cs_low_len", cs_rise_cyc - cs_fall_cyc, 34);

    // Burst with dc switch
    clear_mon();
    push(0, ST7735_DC_CMD, 8'h2A, hs0);
    push(0, ST7735_DC_DATA, 8'h00, hs);
    push(0, ST7735_DC_DATA, 8'h7F, hs);
    wait_idle(0);
    chk("burst_edges", rise_cyc.size(), 24);
    bad = 0;
    for (int i = 1; i < rise_cyc.size(); i++) if (rise_cyc[i] - rise_cyc[i-1] != 4) bad++;
    chk("burst_spacing", bad, 0);
    ones = 0;
    foreach (rise_cs[i]) if (rise_cs[i]) ones++;
    chk("burst_cs_low", ones, 0);
    chk("burst_cs_rises", cs_rise_n, 1);
    first_dc = -1;
    foreach (rise_dc[i]) if (rise_dc[i] && first_dc < 0) first_dc = i;
    chk("burst_first_dc1", first_dc, 8);
    chk("burst_stable", stab_bad, 0);
    chk("burst_b0", rxb(0), 8'h2A);
    chk("burst_b1", rxb(8), 8'h00);
    chk("burst_b2", rxb(16), 8'h7F);

    // Backpressure with 8 distinct bytes
    clear_mon();
    saw_not_ready = 0;
    for (int i = 0; i < 8; i++) begin
      exp_b[i] = 8'(i * 37 + 5);
      push(0, logic'(i % 2), exp_b[i], hs);
    end
    chk("bp_ready_dropped", saw_not_ready, 1'b1);
    wait_idle(0);
    chk("bp_edges", rise_cyc.size(), 64);
    chk("bp_cs_rises", cs_rise_n, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("bp_byte%0d", i), rxb(8 * i), exp_b[i]);
    chk("bp_busy_end", busy, 1'b0);
    chk("bp_stable", stab_bad, 0);

    // Reset mid-byte
    clear_mon();
    push(0, ST7735_DC_DATA, 8'h96, hs);
    push(0, ST7735_DC_DATA, 8'h69, hs);
    push(0, ST7735_DC_CMD, 8'hF0, hs);
    bad = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (rise_cyc.size() >= 3) begin bad = 0; break; end
    end
    chk("mid_third_edge", bad, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_pins("mid");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mon();
    repeat (40) @(posedge clk);
    #1;
    chk("mid_no_edges", rise_cyc.size(), 0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_cs", cs, 1'b1);

    // CLK_DIV=1
    clear_mon();
    push(1, ST7735_DC_DATA, 8'h3C, hs);
    wait_idle(1);
    chk("d1_edges", r1_cyc.size(), 8);
    chk("d1_first_rise", r1_cyc.size() > 0 ? r1_cyc[0] : -1, hs + 2);
    bad = 0;
    for (int i = 1; i < r1_cyc.size(); i++) if (r1_cyc[i] - r1_cyc[i-1] != 2) bad++;
    chk("d1_period", bad, 0);
    v = '0;
    foreach (r1_bit[i]) v = {v[6:0], r1_bit[i]};
    chk("d1_byte", v, 8'h3C);
    chk("d1_span", fall1_cyc - cs1_fall, 16);
    chk("d1_cs_rise", cs1_rise - fall1_cyc, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
